// File: rtl/dmem_access_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the data memory and the arbiter.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface dmem_access_arbiter_if #(
   parameter int unsigned DATA_W = 64
);
   logic              if_req;
   logic [63:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;

   logic              dm_req;
   logic              dm_we;
   logic [63:0]       dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_err;

   logic              mem_en;
   logic              mem_we;
   logic [63:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, if_err,
      output dm_gnt, dm_rvalid, dm_rdata, dm_err,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Shares a single-port data memory between fetch and load/store requesters with a checked,
// multi-cycle access FSM. Define ARB_ROUND_ROBIN_EN for round-robin; default is dm-over-if priority.
module dmem_access_arbiter #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_MAX = 1023,
   parameter int unsigned ALIGN_B  = 2,
   parameter int unsigned MEM_LAT  = 2
) (
   input logic               clk,
   input logic               reset,
   dmem_access_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [1:0] S_ERR    = 2'd3;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DM    = 1'b1;

   localparam int unsigned      LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              owner_q, owner_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [63:0]       mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_err_q, if_err_d;
   logic              dm_rvalid_q, dm_rvalid_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              dm_err_q, dm_err_d;

   logic              grant;
   logic              pick_dm;
   logic              req_we;
   logic              req_invalid;
   logic [63:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] resp_data;

   assign grant = (state_q == S_IDLE) && (bus.if_req || bus.dm_req);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_winner_q;

   always_comb begin
      pick_dm = bus.dm_req;
      if (bus.dm_req && bus.if_req) pick_dm = (last_winner_q == OWN_FETCH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      last_winner_q <= OWN_FETCH;
      else if (grant) last_winner_q <= pick_dm ? OWN_DM : OWN_FETCH;
   end
`else
   assign pick_dm = bus.dm_req;
`endif

   assign bus.dm_gnt = grant && pick_dm;
   assign bus.if_gnt = grant && !pick_dm;

   assign req_addr    = pick_dm ? bus.dm_addr : bus.if_addr;
   assign req_we      = pick_dm && bus.dm_we;
   assign req_wdata   = pick_dm ? bus.dm_wdata : '0;
   assign req_invalid = (req_addr > 64'(ADDR_MAX)) || (req_addr[ALIGN_B-1:0] != '0);

   // Stores answer with zero data; loads and fetches return the word read on the last cycle.
   assign resp_data = mem_we_q ? '0 : bus.mem_rdata;

   always_comb begin
      // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
      state_d     = state_q;
      lat_d       = lat_q;
      owner_d     = owner_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if_rvalid_d = 1'b0;
      if_rdata_d  = '0;
      if_err_d    = 1'b0;
      dm_rvalid_d = 1'b0;
      dm_rdata_d  = '0;
      dm_err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (grant) begin
               owner_d = pick_dm ? OWN_DM : OWN_FETCH;
               lat_d   = '0;
               if (req_invalid) begin
                  state_d = S_ERR;
                  if (pick_dm) begin
                     dm_rvalid_d = 1'b1;
                     dm_err_d    = 1'b1;
                  end else begin
                     if_rvalid_d = 1'b1;
                     if_err_d    = 1'b1;
                  end
               end else begin
                  state_d     = S_ACCESS;
                  mem_en_d    = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = req_addr;
                  mem_wdata_d = req_wdata;
               end
            end
         end
         S_ACCESS: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_RESP;
               lat_d   = '0;
               if (owner_q == OWN_DM) begin
                  dm_rvalid_d = 1'b1;
                  dm_rdata_d  = resp_data;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = resp_data;
               end
            end else begin
               lat_d       = lat_q + 1'b1;
               mem_en_d    = 1'b1;
               mem_we_d    = mem_we_q;
               mem_addr_d  = mem_addr_q;
               mem_wdata_d = mem_wdata_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         lat_q       <= '0;
         owner_q     <= OWN_FETCH;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         if_err_q    <= 1'b0;
         dm_rvalid_q <= 1'b0;
         dm_rdata_q  <= '0;
         dm_err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         lat_q       <= lat_d;
         owner_q     <= owner_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         dm_rvalid_q <= dm_rvalid_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_err_q    <= dm_err_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_err    = if_err_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.dm_err    = dm_err_q;
   assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter: one instance with MEM_LAT=2, one with MEM_LAT=1.
// Expected arbitration order follows ARB_ROUND_ROBIN_EN when the macro is defined.
module tb_dmem_access_arbiter;
   localparam int unsigned DW = 64;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;

   dmem_access_arbiter_if #(.DATA_W(DW)) ba ();
   dmem_access_arbiter_if #(.DATA_W(DW)) bb ();

   dmem_access_arbiter #(.DATA_W(DW), .ADDR_MAX(1023), .ALIGN_B(2), .MEM_LAT(2)) u_dut_lat2 (
      .clk   (clk),
      .reset (reset),
      .bus   (ba.slave)
   );

   dmem_access_arbiter #(.DATA_W(DW), .ADDR_MAX(1023), .ALIGN_B(2), .MEM_LAT(1)) u_dut_lat1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bb.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic dm_access(input string tag, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] rdata_exp,
                            input logic err_exp);
      step();
      ba.dm_req = 1'b1; ba.dm_we = we; ba.dm_addr = addr; ba.dm_wdata = wdata;
      #1;
      chk({tag, ".c0.dm_gnt"}, ba.dm_gnt, 1);
      chk({tag, ".c0.busy"}, ba.busy, 0);
      step();
      ba.dm_req = 1'b0; ba.dm_we = ~we; ba.dm_addr = '1; ba.dm_wdata = '1;
      #1;
      if (err_exp) begin
         chk({tag, ".c1.mem_en"}, ba.mem_en, 0);
         chk({tag, ".c1.dm_rvalid"}, ba.dm_rvalid, 1);
         chk({tag, ".c1.dm_err"}, ba.dm_err, 1);
         chk({tag, ".c1.dm_rdata"}, ba.dm_rdata, 0);
      end else begin
         for (int c = 1; c <= 2; c++) begin
            if (c == 2) begin
               step();
               #1;
            end
            chk({tag, ".acc.mem_en"}, ba.mem_en, 1);
            chk({tag, ".acc.mem_addr"}, ba.mem_addr, addr);
            chk({tag, ".acc.mem_we"}, ba.mem_we, we);
            if (we) chk({tag, ".acc.mem_wdata"}, ba.mem_wdata, wdata);
            chk({tag, ".acc.dm_rvalid"}, ba.dm_rvalid, 0);
            chk({tag, ".acc.dm_gnt"}, ba.dm_gnt, 0);
         end
         step();
         #1;
         chk({tag, ".c3.dm_rvalid"}, ba.dm_rvalid, 1);
         chk({tag, ".c3.dm_err"}, ba.dm_err, 0);
         chk({tag, ".c3.dm_rdata"}, ba.dm_rdata, rdata_exp);
         chk({tag, ".c3.mem_en"}, ba.mem_en, 0);
      end
      step();
      #1;
      chk({tag, ".end.dm_rvalid"}, ba.dm_rvalid, 0);
      chk({tag, ".end.busy"}, ba.busy, 0);
   endtask

   initial begin
      logic exp_dm;

      reset = 1'b1;
      ba.if_req = 1'b0; ba.if_addr = '0; ba.dm_req = 1'b0; ba.dm_we = 1'b0;
      ba.dm_addr = '0; ba.dm_wdata = '0; ba.mem_rdata = '0;
      bb.if_req = 1'b0; bb.if_addr = '0; bb.dm_req = 1'b0; bb.dm_we = 1'b0;
      bb.dm_addr = '0; bb.dm_wdata = '0; bb.mem_rdata = '0;
      step();
      step();
      #1;
      chk("rst.busy", ba.busy, 0);
      chk("rst.mem_en", ba.mem_en, 0);
      chk("rst.dm_rvalid", ba.dm_rvalid, 0);
      chk("rst.if_rvalid", ba.if_rvalid, 0);
      chk("rst.mem_addr", ba.mem_addr, 0);
      reset = 1'b0;

      // Plain load, store, then the range and alignment boundaries.
      ba.mem_rdata = 64'hDEAD;
      dm_access("ld10", 1'b0, 64'h10, 64'h0, 64'hDEAD, 1'b0);
      dm_access("st3f8", 1'b1, 64'h3F8, 64'h55, 64'h0, 1'b0);
      dm_access("ld400", 1'b0, 64'h400, 64'h0, 64'h0, 1'b1);
      dm_access("ld3fe", 1'b0, 64'h3FE, 64'h0, 64'h0, 1'b1);
      ba.mem_rdata = 64'h1234;
      dm_access("ld3fc", 1'b0, 64'h3FC, 64'h0, 64'h1234, 1'b0);

      // Misaligned fetch reports through the fetch port.
      step();
      ba.if_req = 1'b1; ba.if_addr = 64'h22;
      #1;
      chk("if22.c0.if_gnt", ba.if_gnt, 1);
      step();
      ba.if_req = 1'b0;
      #1;
      chk("if22.c1.if_rvalid", ba.if_rvalid, 1);
      chk("if22.c1.if_err", ba.if_err, 1);
      chk("if22.c1.mem_en", ba.mem_en, 0);
      chk("if22.c1.dm_rvalid", ba.dm_rvalid, 0);
      step();
      #1;
      chk("if22.c2.if_rvalid", ba.if_rvalid, 0);

      // Both requesters held across two grants.
      ba.mem_rdata = 64'hBEEF;
      step();
      ba.if_req = 1'b1; ba.if_addr = 64'h20;
      ba.dm_req = 1'b1; ba.dm_we = 1'b0; ba.dm_addr = 64'h30;
      #1;
      chk("arb.c0.dm_gnt", ba.dm_gnt, 1);
      chk("arb.c0.if_gnt", ba.if_gnt, 0);
      for (int c = 1; c <= 3; c++) begin
         step();
         #1;
         chk("arb.busy.gnts", {ba.if_gnt, ba.dm_gnt}, 0);
      end
      step();
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_dm = 1'b0;
`else
      exp_dm = 1'b1;
`endif
      chk("arb.c4.dm_gnt", ba.dm_gnt, exp_dm);
      chk("arb.c4.if_gnt", ba.if_gnt, !exp_dm);
      step();
      ba.if_req = 1'b0; ba.dm_req = 1'b0;
      #1;
      chk("arb.c5.mem_en", ba.mem_en, 1);
      chk("arb.c5.mem_addr", ba.mem_addr, exp_dm ? 64'h30 : 64'h20);
      step();
      step();
      #1;
      chk("arb.c7.dm_rvalid", ba.dm_rvalid, exp_dm);
      chk("arb.c7.if_rvalid", ba.if_rvalid, !exp_dm);
      chk("arb.c7.dm_rdata", ba.dm_rdata, exp_dm ? 64'hBEEF : 64'h0);
      chk("arb.c7.if_rdata", ba.if_rdata, exp_dm ? 64'h0 : 64'hBEEF);
      step();
      #1;
      chk("arb.c8.busy", ba.busy, 0);

      // Reset in the second ACCESS cycle.
      step();
      ba.dm_req = 1'b1; ba.dm_we = 1'b0; ba.dm_addr = 64'h40;
      #1;
      chk("rstmid.c0.dm_gnt", ba.dm_gnt, 1);
      step();
      ba.dm_req = 1'b0;
      #1;
      chk("rstmid.c1.mem_en", ba.mem_en, 1);
      step();
      #1;
      chk("rstmid.c2.mem_en", ba.mem_en, 1);
      reset = 1'b1;
      #1;
      chk("rstmid.busy", ba.busy, 0);
      chk("rstmid.mem_en", ba.mem_en, 0);
      chk("rstmid.dm_rvalid", ba.dm_rvalid, 0);
      chk("rstmid.if_rvalid", ba.if_rvalid, 0);
      step();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         #1;
         chk("rstmid.after.dm_rvalid", ba.dm_rvalid, 0);
         chk("rstmid.after.mem_en", ba.mem_en, 0);
      end

      // MEM_LAT=1 with dm_req held: a grant every third cycle.
      bb.mem_rdata = 64'h77;
      step();
      bb.dm_req = 1'b1; bb.dm_we = 1'b0; bb.dm_addr = 64'h8;
      for (int c = 0; c <= 6; c++) begin
         #1;
         chk("lat1.dm_gnt", bb.dm_gnt, (c % 3) == 0);
         chk("lat1.busy", bb.busy, (c % 3) != 0);
         chk("lat1.mem_en", bb.mem_en, (c % 3) == 1);
         chk("lat1.dm_rvalid", bb.dm_rvalid, (c % 3) == 2);
         if ((c % 3) == 2) chk("lat1.dm_rdata", bb.dm_rdata, 64'h77);
         step();
      end
      bb.dm_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
